sr_pq_ctrl: RTL

//  Request front-end upstream of the shift-register priority queue. Accepts push/pop/replace

---
 rtl/sr_pq_ctrl_if.sv | 25 ++
 rtl/sr_pq_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sr_pq_ctrl_if.sv
// Client request/response bus of the shift-register priority-queue front-end.
// The master modport is the scheduler side; the slave modport is the controller side.
interface sr_pq_ctrl_if #(
   parameter int unsigned KW = 16,
   parameter int unsigned VW = 16
);
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_op;
   logic [KW+VW-1:0]  req_kv;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [KW+VW-1:0]  rsp_kv;
   logic              rsp_err;

   modport master (
      output req_valid, req_op, req_kv, rsp_ready,
      input  req_ready, rsp_valid, rsp_kv, rsp_err
   );

   modport slave (
      input  req_valid, req_op, req_kv, rsp_ready,
      output req_ready, rsp_valid, rsp_kv, rsp_err
   );
endinterface

// File: rtl/sr_pq_ctrl.sv
// Command front-end for the shift-register priority queue: push/pop/replace strobes,
// occupancy tracking and registered responses. Define SR_PQ_CTRL_STATS_EN for statistics ports.
module sr_pq_ctrl #(
   parameter int unsigned KW          = 16,
   parameter int unsigned VW          = 16,
   parameter int unsigned PQ_CAPACITY = 16,
   parameter int unsigned SETTLE_CYC  = 1,
   localparam int unsigned CW         = $clog2(PQ_CAPACITY + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   sr_pq_ctrl_if.slave         bus,
   output logic                pq_push,
   output logic                pq_pop,
   output logic [KW+VW-1:0]    pq_kvi,
   input  logic [KW+VW-1:0]    pq_head,
   output logic [CW-1:0]       count,
   output logic                full,
   output logic                empty
`ifdef SR_PQ_CTRL_STATS_EN
   ,
   output logic [31:0]         stat_push,
   output logic [31:0]         stat_pop,
   output logic [31:0]         stat_err,
   output logic [CW-1:0]       hwm
`endif
);
   localparam int unsigned KVW = KW + VW;
   localparam logic [2:0]  SETTLE_LOAD = 3'(SETTLE_CYC - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ISSUE  = 2'd1;
   localparam logic [1:0] S_SETTLE = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_PUSH = 2'b01;
   localparam logic [1:0] OP_POP  = 2'b10;

   logic [1:0]     state_q, state_d;
   logic [1:0]     op_q, op_d;
   logic           err_q, err_d;
   logic [2:0]     settle_q, settle_d;
   logic [CW-1:0]  count_q, count_d;
   logic           full_q, full_d, empty_q, empty_d;
   logic           req_ready_q, req_ready_d;
   logic           rsp_valid_q, rsp_valid_d;
   logic [KVW-1:0] rsp_kv_q, rsp_kv_d;
   logic           rsp_err_q, rsp_err_d;
   logic           pq_push_q, pq_push_d, pq_pop_q, pq_pop_d;
   logic [KVW-1:0] pq_kvi_q, pq_kvi_d;

   // State register and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         op_q        <= OP_NOP;
         err_q       <= 1'b0;
         settle_q    <= 3'd0;
         count_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_kv_q    <= '0;
         rsp_err_q   <= 1'b0;
         pq_push_q   <= 1'b0;
         pq_pop_q    <= 1'b0;
         pq_kvi_q    <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         err_q       <= err_d;
         settle_q    <= settle_d;
         count_q     <= count_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_kv_q    <= rsp_kv_d;
         rsp_err_q   <= rsp_err_d;
         pq_push_q   <= pq_push_d;
         pq_pop_q    <= pq_pop_d;
         pq_kvi_q    <= pq_kvi_d;
      end
   end

   // Next-state and next-output logic; strobes are computed at accept so they
   // are high exactly while the FSM sits in ISSUE.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      err_d       = err_q;
      settle_d    = settle_q;
      count_d     = count_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_kv_d    = rsp_kv_q;
      rsp_err_d   = rsp_err_q;
      pq_push_d   = 1'b0;
      pq_pop_d    = 1'b0;
      pq_kvi_d    = pq_kvi_q;
      case (state_q)
         S_IDLE: begin
            req_ready_d = 1'b1;
            if (bus.req_valid && req_ready_q && (bus.req_op != OP_NOP)) begin
               op_d        = bus.req_op;
               err_d       = ((bus.req_op == OP_PUSH) && full_q) ||
                             ((bus.req_op != OP_PUSH) && empty_q);
               pq_push_d   = !err_d && bus.req_op[0];
               pq_pop_d    = !err_d && bus.req_op[1];
               pq_kvi_d    = bus.req_kv;
               req_ready_d = 1'b0;
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (err_q) begin
               rsp_err_d   = 1'b1;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end else begin
               if (op_q == OP_PUSH)
                  count_d = count_q + CW'(1);
               else if (op_q == OP_POP)
                  count_d = count_q - CW'(1);
               if (op_q[1])
                  rsp_kv_d = pq_head;
               settle_d = SETTLE_LOAD;
               state_d  = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (settle_q == 3'd0) begin
               if (op_q == OP_PUSH) begin
                  req_ready_d = 1'b1;
                  state_d     = S_IDLE;
               end else begin
                  rsp_valid_d = 1'b1;
                  state_d     = S_RESP;
               end
            end else begin
               settle_d = settle_q - 3'd1;
            end
         end
         default: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               rsp_err_d   = 1'b0;
               req_ready_d = 1'b1;
               state_d     = S_IDLE;
            end
         end
      endcase
      full_d  = (count_d == CW'(PQ_CAPACITY));
      empty_d = (count_d == '0);
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_kv    = rsp_kv_q;
   assign bus.rsp_err   = rsp_err_q;
   assign pq_push       = pq_push_q;
   assign pq_pop        = pq_pop_q;
   assign pq_kvi        = pq_kvi_q;
   assign count         = count_q;
   assign full          = full_q;
   assign empty         = empty_q;

`ifdef SR_PQ_CTRL_STATS_EN
   // Saturating event counters, sampled once per command in ISSUE; replace counts as push and pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_push <= '0;
         stat_pop  <= '0;
         stat_err  <= '0;
         hwm       <= '0;
      end else begin
         if (state_q == S_ISSUE) begin
            if (err_q) begin
               if (stat_err != '1) stat_err <= stat_err + 32'd1;
            end else begin
               if (op_q[0] && (stat_push != '1)) stat_push <= stat_push + 32'd1;
               if (op_q[1] && (stat_pop != '1))  stat_pop  <= stat_pop + 32'd1;
            end
         end
         if (count_d > hwm) hwm <= count_d;
      end
   end
`endif

endmodule
